// File: rtl/execute.sv
// ALU/execute pipeline stage: operand forwarding, ALU and address generation,
// the NVZ flag register and the sticky halt, all registered for MEM/WB.
module execute (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  iOpcode,
    input  logic [15:0] iImm,
    input  logic [3:0]  iSr1,
    input  logic [3:0]  iSr2,
    input  logic [15:0] iData1,
    input  logic [15:0] iData2,
    input  logic        iAlutoReg,
    input  logic        iMemtoReg,
    input  logic        iBustoReg,
    input  logic [3:0]  iWriteBackAddr,
    input  logic        iALUSrc,
    input  logic        iMemRead,
    input  logic        iMemWrite,
    input  logic        iBusWrite,
    input  logic        iWB_en,
    input  logic [3:0]  iWB_addr,
    input  logic [15:0] iWB_data,
    output logic [15:0] oResult,
    output logic [15:0] oStoreData,
    output logic [3:0]  oWriteBackAddr,
    output logic        oAlutoReg,
    output logic        oMemtoReg,
    output logic        oBustoReg,
    output logic        oMemRead,
    output logic        oMemWrite,
    output logic        oBusWrite,
    output logic [2:0]  oNVZ,
    output logic        oHalt
);

    typedef enum logic [4:0] {
        OP_ADD     = 5'b00000,
        OP_SUB     = 5'b00001,
        OP_AND     = 5'b00010,
        OP_OR      = 5'b00011,
        OP_XOR     = 5'b00100,
        OP_NOP     = 5'b00101,
        OP_SLL     = 5'b00110,
        OP_BRANCH  = 5'b00111,
        OP_IMML    = 5'b01000,
        OP_IMMH    = 5'b01001,
        OP_LOAD    = 5'b01010,
        OP_STORE   = 5'b01011,
        OP_DBLOAD  = 5'b01100,
        OP_DBSTORE = 5'b01101,
        OP_HALT    = 5'b01111
    } opcode_t;

    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [15:0] sum;
    logic [15:0] diff;
    logic [15:0] result;
    logic        overflow;
    logic        flag_we;
    logic        halting;

    // The immediate's upper byte and the ALU-source bit carry nothing this stage needs.
    logic unused_inputs;
    assign unused_inputs = ^{iALUSrc, iImm[15:8]};

    // EX result is the younger write, so it beats MEM/WB; r0 is never forwarded.
    always_comb begin
        op_a = iData1;
        if (iSr1 != 4'd0 && oAlutoReg && oWriteBackAddr == iSr1)
            op_a = oResult;
        else if (iSr1 != 4'd0 && iWB_en && iWB_addr == iSr1)
            op_a = iWB_data;

        op_b = iData2;
        if (iSr2 != 4'd0 && oAlutoReg && oWriteBackAddr == iSr2)
            op_b = oResult;
        else if (iSr2 != 4'd0 && iWB_en && iWB_addr == iSr2)
            op_b = iWB_data;
    end

    assign sum  = op_a + op_b;
    assign diff = op_a - op_b;

    always_comb begin
        result   = 16'h0000;
        overflow = 1'b0;
        flag_we  = 1'b0;
        case (iOpcode)
            OP_ADD: begin
                result   = sum;
                overflow = (op_a[15] == op_b[15]) && (sum[15] != op_a[15]);
                flag_we  = 1'b1;
            end
            OP_SUB: begin
                result   = diff;
                overflow = (op_a[15] != op_b[15]) && (diff[15] != op_a[15]);
                flag_we  = 1'b1;
            end
            OP_AND: begin
                result  = op_a & op_b;
                flag_we = 1'b1;
            end
            OP_OR: begin
                result  = op_a | op_b;
                flag_we = 1'b1;
            end
            OP_XOR: begin
                result  = op_a ^ op_b;
                flag_we = 1'b1;
            end
            OP_SLL: begin
                result  = op_a << op_b[3:0];
                flag_we = 1'b1;
            end
            OP_IMML:    result = {8'h00, iImm[7:0]};
            OP_IMMH:    result = {iImm[7:0], op_a[7:0]};
            OP_LOAD,
            OP_STORE,
            OP_DBLOAD,
            OP_DBSTORE: result = op_a;
            default:    result = 16'h0000;
        endcase
    end

    // HALT itself already suppresses side effects so nothing leaks in its wake.
    assign halting = oHalt || (iOpcode == OP_HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oResult        <= 16'h0000;
            oStoreData     <= 16'h0000;
            oWriteBackAddr <= 4'd0;
            oAlutoReg      <= 1'b0;
            oMemtoReg      <= 1'b0;
            oBustoReg      <= 1'b0;
            oMemRead       <= 1'b0;
            oMemWrite      <= 1'b0;
            oBusWrite      <= 1'b0;
            oNVZ           <= 3'b000;
            oHalt          <= 1'b0;
        end else begin
            oResult        <= result;
            oStoreData     <= op_b;
            oWriteBackAddr <= iWriteBackAddr;
            oAlutoReg      <= iAlutoReg && !halting;
            oMemtoReg      <= iMemtoReg && !halting;
            oBustoReg      <= iBustoReg && !halting;
            oMemRead       <= iMemRead  && !halting;
            oMemWrite      <= iMemWrite && !halting;
            oBusWrite      <= iBusWrite && !halting;
            if (flag_we && !oHalt)
                oNVZ <= {result[15], overflow, (result == 16'h0000)};
            if (iOpcode == OP_HALT)
                oHalt <= 1'b1;
        end
    end

endmodule

// File: tb/tb_execute.sv
// Table-driven scoreboard bench for the execute stage, plus a hand-written
// asynchronous mid-stream reset sequence.
module tb_execute;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  iOpcode;
    logic [15:0] iImm;
    logic [3:0]  iSr1, iSr2;
    logic [15:0] iData1, iData2;
    logic        iAlutoReg, iMemtoReg, iBustoReg;
    logic [3:0]  iWriteBackAddr;
    logic        iALUSrc, iMemRead, iMemWrite, iBusWrite;
    logic        iWB_en;
    logic [3:0]  iWB_addr;
    logic [15:0] iWB_data;
    logic [15:0] oResult, oStoreData;
    logic [3:0]  oWriteBackAddr;
    logic        oAlutoReg, oMemtoReg, oBustoReg, oMemRead, oMemWrite, oBusWrite;
    logic [2:0]  oNVZ;
    logic        oHalt;

    execute dut (
        .clk(clk), .rst_n(rst_n),
        .iOpcode(iOpcode), .iImm(iImm), .iSr1(iSr1), .iSr2(iSr2),
        .iData1(iData1), .iData2(iData2),
        .iAlutoReg(iAlutoReg), .iMemtoReg(iMemtoReg), .iBustoReg(iBustoReg),
        .iWriteBackAddr(iWriteBackAddr), .iALUSrc(iALUSrc),
        .iMemRead(iMemRead), .iMemWrite(iMemWrite), .iBusWrite(iBusWrite),
        .iWB_en(iWB_en), .iWB_addr(iWB_addr), .iWB_data(iWB_data),
        .oResult(oResult), .oStoreData(oStoreData), .oWriteBackAddr(oWriteBackAddr),
        .oAlutoReg(oAlutoReg), .oMemtoReg(oMemtoReg), .oBustoReg(oBustoReg),
        .oMemRead(oMemRead), .oMemWrite(oMemWrite), .oBusWrite(oBusWrite),
        .oNVZ(oNVZ), .oHalt(oHalt)
    );

    always #5 clk = ~clk;

    // Control bits are packed {alu, mem, bus, memread, memwrite, buswrite}.
    typedef struct {
        logic [4:0]  op;
        logic [15:0] imm;
        logic [3:0]  sr1, sr2;
        logic [15:0] d1, d2;
        logic [5:0]  ctl;
        logic [3:0]  wba;
        logic        wb_en;
        logic [3:0]  wb_addr;
        logic [15:0] wb_data;
        logic [15:0] e_result, e_store;
        logic [5:0]  e_ctl;
        logic [2:0]  e_nvz;
        logic        e_halt;
    } vec_t;

    typedef struct {
        int          id;
        logic [15:0] result, store;
        logic [3:0]  wba;
        logic [5:0]  ctl;
        logic [2:0]  nvz;
        logic        halt;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[22];
    vec_t post_reset;
    int total = 0;
    int bad   = 0;

    task automatic check1(input string name, input int id,
                          input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s vec%0d: got %h expected %h", name, id, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int id);
        exp_t e;
        @(negedge clk);
        iOpcode = v.op; iImm = v.imm; iSr1 = v.sr1; iSr2 = v.sr2;
        iData1 = v.d1; iData2 = v.d2;
        {iAlutoReg, iMemtoReg, iBustoReg, iMemRead, iMemWrite, iBusWrite} = v.ctl;
        iWriteBackAddr = v.wba; iALUSrc = 1'b0;
        iWB_en = v.wb_en; iWB_addr = v.wb_addr; iWB_data = v.wb_data;
        e.id = id; e.result = v.e_result; e.store = v.e_store; e.wba = v.wba;
        e.ctl = v.e_ctl; e.nvz = v.e_nvz; e.halt = v.e_halt;
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard: no expected entry queued");
        end else begin
            e = sb.pop_front();
            check1("result", e.id, oResult, e.result);
            check1("store",  e.id, oStoreData, e.store);
            check1("wbaddr", e.id, 16'(oWriteBackAddr), 16'(e.wba));
            check1("ctl",    e.id,
                   16'({oAlutoReg, oMemtoReg, oBustoReg, oMemRead, oMemWrite, oBusWrite}),
                   16'(e.ctl));
            check1("nvz",    e.id, 16'(oNVZ), 16'(e.nvz));
            check1("halt",   e.id, 16'(oHalt), 16'(e.halt));
        end
    endtask

    task automatic checkAllZero(input int id);
        check1("rst_result", id, oResult, 16'h0000);
        check1("rst_store",  id, oStoreData, 16'h0000);
        check1("rst_wbaddr", id, 16'(oWriteBackAddr), 16'h0000);
        check1("rst_ctl",    id,
               16'({oAlutoReg, oMemtoReg, oBustoReg, oMemRead, oMemWrite, oBusWrite}),
               16'h0000);
        check1("rst_nvz",    id, 16'(oNVZ), 16'h0000);
        check1("rst_halt",   id, 16'(oHalt), 16'h0000);
    endtask

    initial begin
        //            op     imm      sr1   sr2   d1        d2        ctl       wba   wbe   wba   wbd       result    store     ectl      nvz     halt
        vecs[0]  = '{5'h00, 16'h0000, 4'd1, 4'd2, 16'h7FFF, 16'h0001, 6'b100000, 4'd3, 1'b0, 4'd0, 16'h0000, 16'h8000, 16'h0001, 6'b100000, 3'b110, 1'b0};
        vecs[1]  = '{5'h01, 16'h0000, 4'd4, 4'd5, 16'h1234, 16'h1234, 6'b100000, 4'd6, 1'b0, 4'd0, 16'h0000, 16'h0000, 16'h1234, 6'b100000, 3'b001, 1'b0};
        vecs[2]  = '{5'h05, 16'h0000, 4'd0, 4'd0, 16'h0000, 16'h0000, 6'b000000, 4'd0, 1'b0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 6'b000000, 3'b001, 1'b0};
        vecs[3]  = '{5'h08, 16'h0055, 4'd0, 4'd0, 16'h0000, 16'h0000, 6'b100000, 4'd3, 1'b0, 4'd0, 16'h0000, 16'h0055, 16'h0000, 6'b100000, 3'b001, 1'b0};
        vecs[4]  = '{5'h00, 16'h0000, 4'd3, 4'd3, 16'h0000, 16'h0000, 6'b100000, 4'd4, 1'b0, 4'd0, 16'h0000, 16'h00AA, 16'h0055, 6'b100000, 3'b000, 1'b0};
        vecs[5]  = '{5'h08, 16'h0010, 4'd0, 4'd0, 16'h0000, 16'h0000, 6'b100000, 4'd5, 1'b1, 4'd5, 16'h0020, 16'h0010, 16'h0000, 6'b100000, 3'b000, 1'b0};
        vecs[6]  = '{5'h02, 16'h0000, 4'd5, 4'd5, 16'h0000, 16'h0000, 6'b100000, 4'd6, 1'b1, 4'd5, 16'h0020, 16'h0010, 16'h0010, 6'b100000, 3'b000, 1'b0};
        vecs[7]  = '{5'h08, 16'h0010, 4'd0, 4'd0, 16'h0000, 16'h0000, 6'b100000, 4'd0, 1'b1, 4'd0, 16'h0020, 16'h0010, 16'h0000, 6'b100000, 3'b000, 1'b0};
        vecs[8]  = '{5'h02, 16'h0000, 4'd0, 4'd0, 16'h0000, 16'h0000, 6'b100000, 4'd6, 1'b1, 4'd0, 16'h0020, 16'h0000, 16'h0000, 6'b100000, 3'b001, 1'b0};
        vecs[9]  = '{5'h03, 16'h0000, 4'd7, 4'd8, 16'h1111, 16'h0000, 6'b100000, 4'd9, 1'b1, 4'd8, 16'h0F00, 16'h1F11, 16'h0F00, 6'b100000, 3'b000, 1'b0};
        vecs[10] = '{5'h04, 16'h0000, 4'd9, 4'd2, 16'h0000, 16'hFFFF, 6'b100000, 4'd10, 1'b0, 4'd0, 16'h0000, 16'hE0EE, 16'hFFFF, 6'b100000, 3'b100, 1'b0};
        vecs[11] = '{5'h06, 16'h0000, 4'd1, 4'd2, 16'h0F00, 16'h0014, 6'b100000, 4'd10, 1'b0, 4'd0, 16'h0000, 16'hF000, 16'h0014, 6'b100000, 3'b100, 1'b0};
        vecs[12] = '{5'h0B, 16'h0000, 4'd1, 4'd2, 16'h0040, 16'hBEEF, 6'b000010, 4'd0, 1'b0, 4'd0, 16'h0000, 16'h0040, 16'hBEEF, 6'b000010, 3'b100, 1'b0};
        vecs[13] = '{5'h0A, 16'h0000, 4'd1, 4'd0, 16'h0080, 16'h0000, 6'b010100, 4'd11, 1'b0, 4'd0, 16'h0000, 16'h0080, 16'h0000, 6'b010100, 3'b100, 1'b0};
        vecs[14] = '{5'h01, 16'h0000, 4'd11, 4'd2, 16'h8000, 16'h0001, 6'b100000, 4'd12, 1'b0, 4'd0, 16'h0000, 16'h7FFF, 16'h0001, 6'b100000, 3'b010, 1'b0};
        vecs[15] = '{5'h07, 16'h0000, 4'd0, 4'd0, 16'h0000, 16'h0000, 6'b000000, 4'd0, 1'b0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 6'b000000, 3'b010, 1'b0};
        vecs[16] = '{5'h09, 16'h00AB, 4'd1, 4'd0, 16'h12CD, 16'h0000, 6'b100000, 4'd1, 1'b0, 4'd0, 16'h0000, 16'hABCD, 16'h0000, 6'b100000, 3'b010, 1'b0};
        vecs[17] = '{5'h0D, 16'h0000, 4'd1, 4'd2, 16'h0000, 16'h5555, 6'b000001, 4'd0, 1'b0, 4'd0, 16'h0000, 16'hABCD, 16'h5555, 6'b000001, 3'b010, 1'b0};
        vecs[18] = '{5'h0C, 16'h0000, 4'd4, 4'd0, 16'h0200, 16'h0000, 6'b001000, 4'd13, 1'b0, 4'd0, 16'h0000, 16'h0200, 16'h0000, 6'b001000, 3'b010, 1'b0};
        vecs[19] = '{5'h10, 16'h0000, 4'd4, 4'd0, 16'h1234, 16'h0000, 6'b100000, 4'd5, 1'b0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 6'b100000, 3'b010, 1'b0};
        vecs[20] = '{5'h0F, 16'h0000, 4'd0, 4'd0, 16'h0000, 16'h0000, 6'b000000, 4'd0, 1'b0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 6'b000000, 3'b010, 1'b1};
        vecs[21] = '{5'h00, 16'h0000, 4'd1, 4'd2, 16'h0001, 16'h0001, 6'b111111, 4'd7, 1'b0, 4'd0, 16'h0000, 16'h0002, 16'h0001, 6'b000000, 3'b010, 1'b1};
        post_reset = '{5'h00, 16'h0000, 4'd1, 4'd2, 16'h7FFF, 16'h0001, 6'b100000, 4'd3, 1'b0, 4'd0, 16'h0000, 16'h8000, 16'h0001, 6'b100000, 3'b110, 1'b0};

        iOpcode = 5'h05; iImm = 16'h0; iSr1 = 4'd0; iSr2 = 4'd0;
        iData1 = 16'h0; iData2 = 16'h0;
        {iAlutoReg, iMemtoReg, iBustoReg, iMemRead, iMemWrite, iBusWrite} = 6'b0;
        iWriteBackAddr = 4'd0; iALUSrc = 1'b0;
        iWB_en = 1'b0; iWB_addr = 4'd0; iWB_data = 16'h0;

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2 checkAllZero(100);
        #4 rst_n = 1'b1;

        for (int i = 0; i < 22; i++) begin
            applyStimulus(vecs[i], i);
            checkOutput();
        end

        // Halted stage mid-stream: reset must clear everything without a clock edge.
        @(negedge clk);
        iOpcode = 5'h00; iSr1 = 4'd1; iSr2 = 4'd2; iData1 = 16'h1111; iData2 = 16'h2222;
        {iAlutoReg, iMemtoReg, iBustoReg, iMemRead, iMemWrite, iBusWrite} = 6'b111111;
        iWriteBackAddr = 4'd9;
        #2 rst_n = 1'b0;
        #1 checkAllZero(101);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(post_reset, 102);
        checkOutput();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/execute.md
# execute

Second pipeline stage of the CPU: the ALU/execute stage sitting between fetch/decode and MEM/WB. It consumes the registered decoded instruction, operand data and control bits from fetch/decode, and resolves operand hazards by forwarding. It computes ALU results or memory/bus addresses, maintains the NVZ flag register fed back to decode, and registers everything MEM/WB needs. It also detects HALT and raises the halt signal that freezes fetch.

## Interface
- No parameters. Datapath is fixed at 16 bits.

Ports:
- clk  in  1  system clock, all state on posedge
- rst_n  in  1  asynchronous active-low reset
- iOpcode  in  5  decoded opcode
- iImm  in  16  zero-extended immediate (nonzero only for ImmL/ImmH)
- iSr1, iSr2  in  4 each  source register indices (iSr2 = dest index for Store)
- iData1, iData2  in  16 each  register-file read data
- iAlutoReg, iMemtoReg, iBustoReg  in  1 each  writeback source select
- iWriteBackAddr  in  4  destination register
- iALUSrc, iMemRead, iMemWrite, iBusWrite  in  1 each  control bits
- iWB_en  in  1  MEM/WB writeback enable (forwarding source)
- iWB_addr  in  4  MEM/WB writeback register
- iWB_data  in  16  MEM/WB writeback data
- oResult  out  16  ALU result or memory/bus address
- oStoreData  out  16  forwarded operand 2, used as the Store/DbStore data
- oWriteBackAddr  out  4  registered destination
- oAlutoReg, oMemtoReg, oBustoReg  out  1 each  registered writeback selects
- oMemRead, oMemWrite, oBusWrite  out  1 each  registered control bits
- oNVZ  out  3  flag register {N,V,Z}, to decode
- oHalt  out  1  sticky halt, to decode

## Operation
- Opcode map:
  - 00000 ADD, 00001 SUB, 00010 AND, 00011 OR, 00100 XOR
  - 00101 NOP (the decode bubble word 0x280000 decodes to this with dest 0)
  - 00110 SLL
  - 00111 Branch, 01000 ImmL, 01001 ImmH, 01010 Load, 01011 Store, 01100 DbLoad, 01101 DbStore
  - 01111 HALT
  - All other opcodes behave as NOP.
- Forwarding: operand A is selected for iSr1 and operand B for iSr2, each with the following priority.
  - (1) Previous EX result: when oAlutoReg=1, oWriteBackAddr == index, and index != 0, use oResult.
  - (2) MEM/WB: when iWB_en=1, iWB_addr == index, and index != 0, use iWB_data.
  - (3) Otherwise use iData1 / iData2.
  - Index 0 is never forwarded and always reads iData (0).
- Result by opcode:
  - ADD: A+B. SUB: A−B. Both wrap mod 2^16.
  - AND, OR, XOR: bitwise on A and B.
  - SLL: A << B[3:0], with zero fill.
  - ImmL: {8'h00, iImm[7:0]}.
  - ImmH: {iImm[7:0], A[7:0]}.
  - Load, Store, DbLoad, DbStore: address = A.
  - NOP, Branch, HALT: result 0.
- oStoreData = B for every opcode.
- Flags are updated only by ADD, SUB, AND, OR, XOR and SLL.
  - N = result[15].
  - Z = (result == 0).
  - V is signed overflow for ADD/SUB, i.e. operand signs that make the result sign impossible. V = 0 for logic ops and SLL.
- Every other opcode holds oNVZ.
- Control bits pass through registered, unchanged.
- HALT in EX sets oHalt at the next posedge. oHalt stays set until reset.
- While oHalt=1:
  - oAlutoReg, oMemtoReg, oBustoReg, oMemRead, oMemWrite and oBusWrite are forced to 0.
  - oNVZ is held.
  - The stage therefore issues no side effects after HALT.

## Timing
- Single-cycle stage: inputs sampled at posedge N, and all outputs are registered and valid after posedge N.
- oNVZ changes at the posedge that retires the flag-setting instruction from EX. A branch decoded in the same cycle as that instruction sits in EX sees the old flags; this is a software-visible rule with one delay slot.
- EX→EX forwarding covers back-to-back dependencies with zero stall.
- A Load result is not forwardable from EX because oAlutoReg=0. Decode's one-cycle bubble after Load is what lets MEM/WB forward the loaded value.
- When both forwarding sources match, the EX source wins, since it is the younger write.
- Reset asserted at any time, including mid-stream, immediately sets all outputs to 0: oResult, oStoreData, oWriteBackAddr, every control bit, oNVZ=3'b000 and oHalt=0. No instruction in flight completes.

## Test plan
- ADD 0x7FFF+0x0001 with no hazard -> oResult=0x8000, oNVZ=3'b110 one cycle later.
- SUB equal operands 0x1234−0x1234 -> oResult=0x0000, oNVZ=3'b001. A following NOP holds oNVZ=3'b001.
- Back-to-back: ImmL r3←0x55, then ADD r4=r3+r3 with stale iData1=iData2=0 -> oResult=0x00AA via EX forwarding.
- Dual match: prior EX writes r5=0x0010 and iWB writes r5=0x0020 in the same cycle, then AND r6=r5&r5 -> 0x0010. The same scenario with target r0 -> uses iData (0).
- Store r2→[r1] with r1=0x0040, r2=0xBEEF -> oResult=0x0040, oStoreData=0xBEEF, oMemWrite=1, oAlutoReg=0, flags unchanged.
- HALT followed by ADD; then assert rst_n low mid-stream -> oHalt=1 and all writeback/memory enables 0 from the cycle after HALT. Reset then clears oHalt, oNVZ and all outputs to 0 asynchronously.
